// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel-source and DAC pin bundle of the VGA timing generator
interface vga_timing_gen_if #(
   parameter int COLOR_W = 8,
   parameter int XW      = 10,
   parameter int YW      = 10
);
   logic [1:0]           mode;
   logic [3*COLOR_W-1:0] solid_rgb;
   logic [COLOR_W-1:0]   ext_r;
   logic [COLOR_W-1:0]   ext_g;
   logic [COLOR_W-1:0]   ext_b;
   logic [XW-1:0]        pix_x;
   logic [YW-1:0]        pix_y;
   logic                 pix_req;
   logic                 frame_start;
   logic                 vga_HS;
   logic                 vga_VS;
   logic [COLOR_W-1:0]   R;
   logic [COLOR_W-1:0]   G;
   logic [COLOR_W-1:0]   B;

   modport master (
      input  mode, solid_rgb, ext_r, ext_g, ext_b,
      output pix_x, pix_y, pix_req, frame_start, vga_HS, vga_VS, R, G, B
   );

   modport slave (
      output mode, solid_rgb, ext_r, ext_g, ext_b,
      input  pix_x, pix_y, pix_req, frame_start, vga_HS, vga_VS, R, G, B
   );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA sync/pixel generator on a pixel-clock enable
// Stage 0 counters, stage 1 request/sync copies, stage 2 registered pins.
module vga_timing_gen #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int HS_POL     = 0,
   parameter int VS_POL     = 0,
   parameter int CLK_DIV    = 2,
   parameter int COLOR_W    = 8,
   parameter int CHECK_LOG2 = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   vga_timing_gen_if.master vga
);
   localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int   XW      = $clog2(H_TOTAL);
   localparam int   YW      = $clog2(V_TOTAL);
   localparam int   DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic HS_ON   = (HS_POL != 0);
   localparam logic VS_ON   = (VS_POL != 0);

   logic [DW-1:0]      div_q, div_d;
   logic               tick;
   logic [XW-1:0]      cx_q, cx_d;
   logic [YW-1:0]      cy_q, cy_d;
   logic [1:0]         mode_q, mode_d;
   logic               de0, hs0, vs0, at_origin;

   logic [XW-1:0]      pix_x_q, pix_x_d;
   logic [YW-1:0]      pix_y_q, pix_y_d;
   logic               pix_req_q, pix_req_d;
   logic               hs1_q, hs1_d;
   logic               vs1_q, vs1_d;
   logic               fs_q, fs_d;

   logic               hs_q, hs_d;
   logic               vs_q, vs_d;
   logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic [COLOR_W-1:0] pr, pg, pb;
   logic [2:0]         bar;
   logic               chk_x, chk_y;

   assign tick = (CLK_DIV == 1) ? 1'b1 : (32'(div_q) == CLK_DIV - 1);

   assign de0       = (32'(cx_q) < H_ACTIVE) && (32'(cy_q) < V_ACTIVE);
   assign hs0       = (32'(cx_q) >= H_ACTIVE + H_FP) && (32'(cx_q) < H_ACTIVE + H_FP + H_SYNC);
   assign vs0       = (32'(cy_q) >= V_ACTIVE + V_FP) && (32'(cy_q) < V_ACTIVE + V_FP + V_SYNC);
   assign at_origin = (cx_q == '0) && (cy_q == '0);

   always_comb begin : p_stage0
      div_d  = div_q;
      cx_d   = cx_q;
      cy_d   = cy_q;
      mode_d = mode_q;
      if (tick) begin
         div_d = '0;
         if (32'(cx_q) == H_TOTAL - 1) begin
            cx_d = '0;
            cy_d = (32'(cy_q) == V_TOTAL - 1) ? '0 : cy_q + 1'b1;
         end else begin
            cx_d = cx_q + 1'b1;
         end
         // Mode only changes at the frame origin so a frame is never torn.
         if (at_origin) mode_d = vga.mode;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_comb begin : p_stage1
      pix_x_d   = pix_x_q;
      pix_y_d   = pix_y_q;
      pix_req_d = pix_req_q;
      hs1_d     = hs1_q;
      vs1_d     = vs1_q;
      fs_d      = tick && at_origin;
      if (tick) begin
         pix_x_d   = cx_q;
         pix_y_d   = cy_q;
         pix_req_d = de0;
         hs1_d     = hs0;
         vs1_d     = vs0;
      end
   end

   always_comb begin : p_bar
      bar = '0;
      for (int i = 1; i < 8; i++)
         if (32'(pix_x_q) >= (i * H_ACTIVE) / 8) bar = 3'(i);
   end

   if (CHECK_LOG2 < XW) begin : g_chk_x
      assign chk_x = pix_x_q[CHECK_LOG2];
   end else begin : g_chk_x0
      assign chk_x = 1'b0;
   end

   if (CHECK_LOG2 < YW) begin : g_chk_y
      assign chk_y = pix_y_q[CHECK_LOG2];
   end else begin : g_chk_y0
      assign chk_y = 1'b0;
   end

   always_comb begin : p_colour
      pr = '0;
      pg = '0;
      pb = '0;
      case (mode_q)
         2'd0: begin
            pr = vga.solid_rgb[3*COLOR_W-1 -: COLOR_W];
            pg = vga.solid_rgb[2*COLOR_W-1 -: COLOR_W];
            pb = vga.solid_rgb[COLOR_W-1:0];
         end
         // Bar order white..black maps each channel onto one inverted index bit.
         2'd1: begin
            pr = {COLOR_W{~bar[1]}};
            pg = {COLOR_W{~bar[2]}};
            pb = {COLOR_W{~bar[0]}};
         end
         2'd2: begin
            pr = {COLOR_W{chk_x ^ chk_y}};
            pg = {COLOR_W{chk_x ^ chk_y}};
            pb = {COLOR_W{chk_x ^ chk_y}};
         end
         default: begin
            pr = vga.ext_r;
            pg = vga.ext_g;
            pb = vga.ext_b;
         end
      endcase
   end

   always_comb begin : p_stage2
      hs_d = hs_q;
      vs_d = vs_q;
      r_d  = r_q;
      g_d  = g_q;
      b_d  = b_q;
      if (tick) begin
         hs_d = hs1_q ? HS_ON : ~HS_ON;
         vs_d = vs1_q ? VS_ON : ~VS_ON;
         r_d  = pix_req_q ? pr : '0;
         g_d  = pix_req_q ? pg : '0;
         b_d  = pix_req_q ? pb : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q     <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         mode_q    <= '0;
         pix_x_q   <= '0;
         pix_y_q   <= '0;
         pix_req_q <= 1'b0;
         hs1_q     <= 1'b0;
         vs1_q     <= 1'b0;
         fs_q      <= 1'b0;
         hs_q      <= ~HS_ON;
         vs_q      <= ~VS_ON;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
      end else begin
         div_q     <= div_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         mode_q    <= mode_d;
         pix_x_q   <= pix_x_d;
         pix_y_q   <= pix_y_d;
         pix_req_q <= pix_req_d;
         hs1_q     <= hs1_d;
         vs1_q     <= vs1_d;
         fs_q      <= fs_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
      end
   end

   assign vga.pix_x       = pix_x_q;
   assign vga.pix_y       = pix_y_q;
   assign vga.pix_req     = pix_req_q;
   assign vga.frame_start = fs_q;
   assign vga.vga_HS      = hs_q;
   assign vga.vga_VS      = vs_q;
   assign vga.R           = r_q;
   assign vga.G           = g_q;
   assign vga.B           = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: wide-line instance and tiny instance
`timescale 1ns/1ps
module tb_vga_timing_gen;
   localparam int A_XW = 10;
   localparam int A_YW = 3;
   localparam int B_XW = 4;
   localparam int B_YW = 3;

   logic clk   = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   vga_timing_gen_if #(.COLOR_W(8), .XW(A_XW), .YW(A_YW)) a_if ();
   vga_timing_gen_if #(.COLOR_W(8), .XW(B_XW), .YW(B_YW)) b_if ();

   // 640-pixel lines with a 7-line frame keep whole-frame tests short.
   vga_timing_gen #(
      .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(0), .VS_POL(0), .CLK_DIV(2), .COLOR_W(8), .CHECK_LOG2(5)
   ) dut_a (.clk_i(clk), .rst_i(rst_a), .vga(a_if));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1), .VS_POL(0), .CLK_DIV(1), .COLOR_W(8), .CHECK_LOG2(1)
   ) dut_b (.clk_i(clk), .rst_i(rst_b), .vga(b_if));

   always #10 clk = ~clk;

   // External source: synchronous RAM with one clk of read latency.
   always @(posedge clk) begin
      a_if.ext_r <= a_if.pix_x[7:0];
      a_if.ext_g <= 8'h5A;
      a_if.ext_b <= ~a_if.pix_x[7:0];
   end

   typedef struct {
      logic [1:0]  mode;
      int          x;
      int          y;
      logic [23:0] rgb;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, required %0h", name, got, exp);
   endtask

   function automatic logic [31:0] tiny_exp(input int k);
      int x1, y1, x2, y2;
      logic req, fs, hs, vs;
      logic [7:0] r;
      x1  = (k - 1) % 12;
      y1  = ((k - 1) / 12) % 7;
      req = (x1 < 8) && (y1 < 4);
      fs  = (x1 == 0) && (y1 == 0);
      hs  = 1'b0;
      vs  = 1'b1;
      r   = 8'h00;
      if (k >= 2) begin
         x2 = (k - 2) % 12;
         y2 = ((k - 2) / 12) % 7;
         hs = (x2 == 9) || (x2 == 10);
         vs = (y2 != 5);
         if (x2 < 8 && y2 < 4) r = ((((x2 >> 1) ^ (y2 >> 1)) & 1) != 0) ? 8'hFF : 8'h00;
      end
      return {13'b0, 4'(x1), 3'(y1), req, fs, hs, vs, r};
   endfunction

   function automatic logic [31:0] tiny_got();
      return {13'b0, b_if.pix_x, b_if.pix_y, b_if.pix_req, b_if.frame_start,
              b_if.vga_HS, b_if.vga_VS, b_if.R};
   endfunction

   task automatic wait_pix(input int x, input int y);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30000; i++) begin
         if (a_if.pix_x == 10'(x) && a_if.pix_y == 3'(y)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("wait_pix_timeout", 64'(ok), 64'd1);
   endtask

   task automatic wait_fs();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 25000; i++) begin
         @(negedge clk);
         if (a_if.frame_start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("wait_frame_start_timeout", 64'(ok), 64'd1);
   endtask

   task automatic sample_a(output logic [23:0] rgb);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rgb = {a_if.R, a_if.G, a_if.B};
   endtask

   // Sync / request run-length monitor for dut_a.
   logic hs_prev = 1'b1, vs_prev = 1'b1, req_prev = 1'b0;
   bit   hs_seen = 0, vs_seen = 0, req_seen = 0;
   int   hs_per = 0, hs_low = 0, vs_per = 0, vs_low = 0, req_run = 0;
   int   hs_per_n = 0, hs_per_bad = 0, hs_w_n = 0, hs_w_bad = 0;
   int   vs_per_n = 0, vs_per_bad = 0, vs_w_n = 0, vs_w_bad = 0, vs_align_bad = 0;
   int   req_n = 0, req_bad = 0;

   always @(negedge clk) begin
      if (rst_a) begin
         hs_prev = 1'b1; vs_prev = 1'b1; req_prev = 1'b0;
         hs_seen = 0; vs_seen = 0; req_seen = 0;
         hs_per = 0; hs_low = 0; vs_per = 0; vs_low = 0; req_run = 0;
      end else begin
         if (hs_prev && !a_if.vga_HS) begin
            if (hs_seen) begin hs_per_n++; if (hs_per != 1600) hs_per_bad++; end
            hs_seen = 1; hs_per = 0; hs_low = 0;
         end
         hs_per++;
         if (!a_if.vga_HS) hs_low++;
         if (!hs_prev && a_if.vga_HS && hs_seen) begin hs_w_n++; if (hs_low != 192) hs_w_bad++; end

         if (vs_prev && !a_if.vga_VS) begin
            if (vs_seen) begin vs_per_n++; if (vs_per != 11200) vs_per_bad++; end
            if (a_if.pix_x != 10'd1 || a_if.pix_y != 3'd4) vs_align_bad++;
            vs_seen = 1; vs_per = 0; vs_low = 0;
         end
         vs_per++;
         if (!a_if.vga_VS) vs_low++;
         if (!vs_prev && a_if.vga_VS && vs_seen) begin vs_w_n++; if (vs_low != 3200) vs_w_bad++; end

         if (!req_prev && a_if.pix_req) begin req_seen = 1; req_run = 0; end
         if (a_if.pix_req) req_run++;
         if (req_prev && !a_if.pix_req && req_seen) begin req_n++; if (req_run != 1280) req_bad++; end

         hs_prev  = a_if.vga_HS;
         vs_prev  = a_if.vga_VS;
         req_prev = a_if.pix_req;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   initial begin
      logic [23:0] rgb;
      logic [1:0]  cur_mode;
      logic [7:0]  x8;

      tbl[0]  = '{2'd1,  79, 0, 24'hFFFFFF};
      tbl[1]  = '{2'd1,  80, 0, 24'hFFFF00};
      tbl[2]  = '{2'd1, 159, 0, 24'hFFFF00};
      tbl[3]  = '{2'd1, 160, 0, 24'h00FFFF};
      tbl[4]  = '{2'd1, 400, 0, 24'hFF0000};
      tbl[5]  = '{2'd1, 480, 0, 24'h0000FF};
      tbl[6]  = '{2'd1, 639, 0, 24'h000000};
      tbl[7]  = '{2'd1, 640, 0, 24'h000000};
      tbl[8]  = '{2'd2,  31, 0, 24'h000000};
      tbl[9]  = '{2'd2,  32, 0, 24'hFFFFFF};
      tbl[10] = '{2'd2,  64, 1, 24'h000000};
      tbl[11] = '{2'd2,  96, 1, 24'hFFFFFF};
      tbl[12] = '{2'd0,  10, 0, 24'h123456};
      tbl[13] = '{2'd0, 700, 0, 24'h000000};
      tbl[14] = '{2'd0, 639, 1, 24'h123456};

      a_if.mode      = tbl[0].mode;
      a_if.solid_rgb = 24'h123456;
      b_if.mode      = 2'd2;
      b_if.solid_rgb = 24'h0;
      b_if.ext_r     = 8'h0;
      b_if.ext_g     = 8'h0;
      b_if.ext_b     = 8'h0;
      cur_mode       = tbl[0].mode;

      repeat (5) @(negedge clk);
      check("a_reset", {a_if.pix_x, a_if.pix_y, a_if.pix_req, a_if.frame_start,
                        a_if.vga_HS, a_if.vga_VS, a_if.R, a_if.G, a_if.B},
            {10'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0});
      check("b_reset", 64'(tiny_got()), 64'h100);

      // Tiny instance: every clk is a tick; run past both wraps up to (5,2).
      rst_b = 1'b0;
      for (int k = 1; k <= 113; k++) begin
         @(negedge clk);
         check($sformatf("tiny_cycle_%0d", k), 64'(tiny_got()), 64'(tiny_exp(k)));
      end
      rst_b = 1'b1;
      @(negedge clk);
      check("tiny_midframe_reset", 64'(tiny_got()), 64'h100);
      rst_b = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         check($sformatf("tiny_restart_%0d", k), 64'(tiny_got()), 64'(tiny_exp(k)));
      end
      rst_b = 1'b1;

      // Wide instance, CLK_DIV=2: first tick on the second edge.
      rst_a = 1'b0;
      @(negedge clk);
      check("a_req_before_tick", 64'(a_if.pix_req), 64'd0);
      @(negedge clk);
      check("a_first_req", {a_if.pix_req, a_if.frame_start, a_if.pix_x, a_if.pix_y},
            {1'b1, 1'b1, 10'd0, 3'd0});
      @(negedge clk);
      check("a_fs_one_clk", {a_if.pix_req, a_if.frame_start}, {1'b1, 1'b0});

      for (int i = 0; i < 15; i++) begin
         if (tbl[i].mode != cur_mode) begin
            a_if.mode = tbl[i].mode;
            cur_mode  = tbl[i].mode;
            wait_fs();
         end
         wait_pix(tbl[i].x, tbl[i].y);
         sample_a(rgb);
         check($sformatf("table_%0d_mode%0d_x%0d_y%0d", i, tbl[i].mode, tbl[i].x, tbl[i].y),
               64'(rgb), 64'(tbl[i].rgb));
      end

      // Mid-frame switch to checkerboard: current frame stays solid.
      a_if.mode = 2'd2;
      wait_pix(32, 2);
      sample_a(rgb);
      check("switch_same_frame_solid", 64'(rgb), 64'h123456);
      wait_fs();
      wait_pix(31, 0);
      sample_a(rgb);
      check("switch_next_frame_x31", 64'(rgb), 64'h000000);
      wait_pix(32, 0);
      sample_a(rgb);
      check("switch_next_frame_x32", 64'(rgb), 64'hFFFFFF);

      a_if.mode = 2'd3;
      wait_fs();
      for (int x = 0; x < 640; x++) begin
         wait_pix(x, 0);
         sample_a(rgb);
         x8 = 8'(x);
         check($sformatf("ext_col_%0d", x), 64'(rgb), 64'({x8, 8'h5A, ~x8}));
      end

      check("hs_low_width_errs", 64'(hs_w_bad), 64'd0);
      check("hs_low_width_seen", 64'(hs_w_n > 10), 64'd1);
      check("hs_period_errs", 64'(hs_per_bad), 64'd0);
      check("hs_period_seen", 64'(hs_per_n > 10), 64'd1);
      check("vs_low_width_errs", 64'(vs_w_bad), 64'd0);
      check("vs_period_errs", 64'(vs_per_bad), 64'd0);
      check("vs_period_seen", 64'(vs_per_n >= 2), 64'd1);
      check("vs_line_align_errs", 64'(vs_align_bad), 64'd0);
      check("req_run_errs", 64'(req_bad), 64'd0);
      check("req_run_seen", 64'(req_n > 10), 64'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
